// File: rtl/lag_meter_if.sv
// Measurement bus for lag_meter: gate/feedback inputs and the published shift with its strobes.
interface lag_meter_if #(
  parameter int unsigned W = 8
);
  logic         en;
  logic         sgn;
  logic         fb;
  logic [W-1:0] shift;
  logic         shift_valid;
  logic         timeout;
  logic         overrun;

  modport master (
    output en, sgn, fb,
    input  shift, shift_valid, timeout, overrun
  );

  modport slave (
    input  en, sgn, fb,
    output shift, shift_valid, timeout, overrun
  );
endinterface

// File: rtl/lag_meter.sv
// Measures the delay from a sgn edge to the matching fb edge and publishes the average of
// 2^AVG_LOG2 samples as a shift value with a one-cycle strobe.
module lag_meter #(
  parameter int unsigned CNT_MAX  = 255,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic      clk,
  input  logic      rst,
  lag_meter_if.slave bus
);
  localparam int unsigned W  = $clog2(CNT_MAX + 1);
  localparam int unsigned AW = W + AVG_LOG2;
  localparam logic [W-1:0] CntMax = W'(CNT_MAX);
  localparam logic [AVG_LOG2:0] IdxLast = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StCount, StAccum} state_e;

  state_e            state_q;
  logic              sgn_q;
  logic              fb_s1_q, fb_s2_q, fb_s3_q;
  logic              target_q;
  logic              pend_q;
  logic [W-1:0]      cnt_q;
  logic [W-1:0]      sample_q;
  logic [AW-1:0]     acc_q;
  logic [AVG_LOG2:0] idx_q;
  logic [W-1:0]      shift_q;
  logic              valid_q, timeout_q, overrun_q;

  logic          sgn_edge, fb_edge, fb_match;
  logic [W-1:0]  sample_d;
  logic [AW-1:0] acc_sum;
  logic [W-1:0]  shift_d;

  // Edge-detect pipelines are not reset so a held level never looks like an edge after reset.
  always_ff @(posedge clk) begin
    sgn_q   <= bus.sgn;
    fb_s1_q <= bus.fb;
    fb_s2_q <= fb_s1_q;
    fb_s3_q <= fb_s2_q;
  end

  always_comb begin
    sgn_edge = bus.sgn != sgn_q;
    fb_edge  = fb_s2_q != fb_s3_q;
    fb_match = fb_edge && (fb_s2_q == target_q);
    // Counter runs one ahead of the raw lag; the extra synchronizer cycle is removed here.
    sample_d = (cnt_q == '0) ? '0 : cnt_q - W'(1);
    acc_sum  = acc_q + AW'(sample_q);
    shift_d  = W'(acc_sum >> AVG_LOG2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      target_q  <= 1'b0;
      pend_q    <= 1'b0;
      cnt_q     <= '0;
      sample_q  <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      if (!bus.en) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        acc_q   <= '0;
        idx_q   <= '0;
        pend_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            cnt_q   <= '0;
            state_q <= StArmed;
          end
          StArmed: begin
            if (sgn_edge) begin
              cnt_q    <= '0;
              target_q <= bus.sgn;
              state_q  <= StCount;
            end
          end
          StCount: begin
            if (fb_match) begin
              sample_q <= sample_d;
              state_q  <= StAccum;
              // A coincident sgn edge is replayed from ACCUM with the count it would have had.
              if (sgn_edge) begin
                pend_q   <= 1'b1;
                target_q <= bus.sgn;
              end
            end else if (cnt_q == CntMax) begin
              timeout_q <= 1'b1;
              state_q   <= StArmed;
            end else if (sgn_edge) begin
              overrun_q <= 1'b1;
              cnt_q     <= '0;
              target_q  <= bus.sgn;
            end else begin
              cnt_q <= cnt_q + W'(1);
            end
          end
          StAccum: begin
            if (idx_q == IdxLast) begin
              shift_q <= shift_d;
              valid_q <= 1'b1;
              acc_q   <= '0;
              idx_q   <= '0;
            end else begin
              acc_q <= acc_sum;
              idx_q <= idx_q + 1'b1;
            end
            pend_q <= 1'b0;
            if (sgn_edge) begin
              cnt_q    <= '0;
              target_q <= bus.sgn;
              state_q  <= StCount;
            end else if (pend_q) begin
              cnt_q   <= W'(1);
              state_q <= StCount;
            end else begin
              state_q <= StArmed;
            end
          end
        endcase
      end
    end
  end

  assign bus.shift       = shift_q;
  assign bus.shift_valid = valid_q;
  assign bus.timeout     = timeout_q;
  assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_lag_meter.sv
// Directed and randomized bench for lag_meter against a lag-list averaging model.
module tb_lag_meter;
  localparam int unsigned CntMax  = 255;
  localparam int unsigned AvgLog2 = 2;
  localparam int unsigned W       = 8;
  localparam int          GrpSize = 1 << AvgLog2;

  logic clk = 1'b0;
  logic rst;

  lag_meter_if #(.W(W)) bus ();

  lag_meter #(
    .CNT_MAX (CntMax),
    .AVG_LOG2(AvgLog2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: lags accepted into the current group, and expected published shifts.
  int grp_sum = 0;
  int grp_n = 0;
  int exp_q[$];
  int exp_to = 0;
  int exp_ov = 0;
  int last_exp = 0;

  // Observations gathered away from the active edge.
  int obs_q[$];
  int obs_to = 0;
  int obs_ov = 0;
  int stable_err = 0;
  logic [W-1:0] prev_shift = '0;
  logic prev_rst = 1'b1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.shift_valid) obs_q.push_back(int'(bus.shift));
      if (bus.timeout) obs_to++;
      if (bus.overrun) obs_ov++;
      if (!prev_rst && !bus.shift_valid && bus.shift != prev_shift) stable_err++;
    end
    prev_shift = bus.shift;
    prev_rst   = rst;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void accept(input int lag);
    grp_sum += lag;
    grp_n++;
    if (grp_n == GrpSize) begin
      exp_q.push_back(grp_sum >> AvgLog2);
      last_exp = grp_sum >> AvgLog2;
      grp_sum  = 0;
      grp_n    = 0;
    end
  endfunction

  // One sgn edge followed by the matching fb edge after lag cycles, then enough idle for zero loss.
  task automatic meas(input int lag);
    bus.sgn = ~bus.sgn;
    if (lag == 0) begin
      bus.fb = bus.sgn;
    end else begin
      tick(lag);
      bus.fb = bus.sgn;
    end
    tick(5 + int'($urandom_range(0, 3)));
  endtask

  task automatic meas_acc(input int lag);
    meas(lag);
    accept(lag);
  endtask

  task automatic check_phase(input string tag);
    int n;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_shift"}, obs_q[i], exp_q[i]);
    chk({tag, "_timeout"}, obs_to, exp_to);
    chk({tag, "_overrun"}, obs_ov, exp_ov);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.sgn = 1'b0;
    bus.fb  = 1'b0;
    tick(4);
    chk("rst_shift", int'(bus.shift), 0);
    chk("rst_valid", int'(bus.shift_valid), 0);
    chk("rst_timeout", int'(bus.timeout), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    rst = 1'b0;
    bus.en = 1'b1;
    tick(3);

    for (int i = 0; i < 4; i++) meas_acc(10);
    check_phase("lag10");

    meas_acc(7);
    meas_acc(8);
    meas_acc(8);
    meas_acc(10);
    check_phase("mixed");

    for (int i = 0; i < 4; i++) meas_acc(CntMax - 1);
    check_phase("maxlag");

    // Timeout in the middle of a group must not disturb the partial sum.
    meas_acc(5);
    meas_acc(5);
    bus.sgn = ~bus.sgn;
    tick(CntMax + 5);
    bus.fb = bus.sgn;
    exp_to++;
    tick(6);
    meas_acc(5);
    meas_acc(5);
    check_phase("timeout");

    // Overrun: second sgn edge restarts the count; a wrong-polarity fb edge is ignored.
    bus.sgn = ~bus.sgn;
    tick(3);
    bus.sgn = ~bus.sgn;
    tick(2);
    bus.fb = ~bus.fb;
    tick(4);
    bus.fb = bus.sgn;
    tick(6);
    exp_ov++;
    accept(6);
    for (int i = 0; i < 3; i++) meas_acc(int'($urandom_range(0, 60)));
    check_phase("overrun");

    for (int i = 0; i < 8; i++) meas_acc(int'($urandom_range(0, 60)));
    check_phase("random");

    // Partial group discarded by en=0; shift must hold meanwhile.
    meas(int'($urandom_range(1, 40)));
    meas(int'($urandom_range(1, 40)));
    bus.en = 1'b0;
    tick(3);
    chk("hold_shift", int'(bus.shift), last_exp);
    bus.sgn = ~bus.sgn;
    bus.fb  = bus.sgn;
    tick(6);
    chk("hold_shift2", int'(bus.shift), last_exp);
    bus.en = 1'b1;
    tick(3);
    for (int i = 0; i < 4; i++) meas_acc(12);
    check_phase("endrop");

    // Reset while counting, then zero-lag samples.
    bus.sgn = ~bus.sgn;
    tick(3);
    rst = 1'b1;
    bus.fb = bus.sgn;
    tick(1);
    chk("rstcnt_shift", int'(bus.shift), 0);
    chk("rstcnt_valid", int'(bus.shift_valid), 0);
    chk("rstcnt_timeout", int'(bus.timeout), 0);
    chk("rstcnt_overrun", int'(bus.overrun), 0);
    tick(3);
    rst = 1'b0;
    grp_sum = 0;
    grp_n   = 0;
    tick(4);
    for (int i = 0; i < 4; i++) meas_acc(0);
    check_phase("zerolag");

    chk("shift_stable", stable_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
